hazard_control: RTL
===================

# hazard_control

Pipeline interlock and scheduling controller for the five-stage core (IF, ID, EX, MEM, WB). It watches the operand addresses of the instruction in ID and the destinations of the instructions in EX, MEM and WB. From these it drives the stall, bubble and forwarding selects that feed the decode stage and the ID/EX pipeline registers. It also sequences the shared multi-cycle multiply/divide unit (single issue, busy tracking, HI/LO read interlock) and keeps a free-running stall-cycle counter for performance measurement.

## Interface
- NUM_MD_CYCLES_MAX, 64: watchdog limit on multiply/divide busy cycles; must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- reg_s_addr_id, reg_t_addr_id  in  5  operand register addresses of the instruction in ID.
- uses_s_id, uses_t_id  in  1  the instruction in ID reads the s and t operands, respectively.
- reg_d_we_ex, reg_d_addr_ex  in  1/5  write enable and destination of the instruction in EX.
- reg_d_we_mem, reg_d_addr_mem  in  1/5  write enable and destination of the instruction in MEM.
- reg_d_we_wb, reg_d_addr_wb  in  1/5  write enable and destination of the instruction in WB.
- pc_we_id  in  1  branch-taken request from decode.
- md_start_id  in  1  the instruction in ID is a mult/div.
- md_read_id  in  1  the instruction in ID is mfhi/mflo.
- md_done  in  1  single-cycle completion pulse from the multiply/divide unit.
- stall  out  1  hold the PC and the IF/ID register.
- bubble_ex  out  1  force the ID/EX control fields to a no-op (reg_d_we_ex=0, mem_we_ex=0).
- pc_we  out  1  gated branch enable: pc_we_id & ~stall.
- fwd_s_sel, fwd_t_sel  out  2  operand source: 0 = register file, 1 = MEM result, 2 = WB result.
- md_go  out  1  one-cycle launch pulse to the multiply/divide unit.
- md_busy  out  1  the multiply/divide unit is occupied.
- md_timeout  out  1  sticky error flag.
- stall_count  out  32  count of cycles with stall=1.

## Operation
- Hazard match for operand x in {s,t}:
  - requires uses_x_id=1, reg_x_addr_id≠0, and a producer whose write enable is 1 and whose destination equals reg_x_addr_id.
  - Register 0 never hazards and never forwards.
- ex_hazard: a match against the EX producer for either operand.
- Forward select per operand:
  - MEM match → 1;
  - otherwise WB match → 2;
  - otherwise 0.
  - EX is excluded from forwarding; an EX match is always handled by ex_hazard.
  - Forward selects are computed while stalled and are valid on every cycle.
- md_hazard: (md_start_id | md_read_id) & md_busy.
- stall = ex_hazard | md_hazard. The outputs bubble_ex and stall are always equal.
- Multiply/divide FSM, IDLE → BUSY → IDLE:
  - IDLE: when md_start_id=1 and stall=0, assert md_go for one cycle and go to BUSY. Any other condition stays in IDLE.
  - BUSY: md_busy=1. A 7-bit busy counter increments each cycle.
  - BUSY, md_done=1: go to IDLE.
  - BUSY, counter reaches NUM_MD_CYCLES_MAX−1 without md_done: set md_timeout and go to IDLE.
  - md_done while in IDLE is ignored.
- md_busy is registered, so md_busy=0 on the cycle after md_done. A mult/div waiting in ID issues in that cycle.
- stall_count increments on every cycle with stall=1 and wraps from 0xFFFFFFFF to 0.
- Branch delay slots are architectural, so this block issues no flush. A stalled branch re-evaluates next cycle with refreshed forwarding.

## Timing
- Reset values:
  - FSM in IDLE;
  - md_busy=0, md_go=0, md_timeout=0;
  - stall_count=0;
  - busy counter=0.
- Combinational from inputs: stall, bubble_ex, pc_we, fwd_*_sel. md_go is combinational from the IDLE state and the inputs.
- Latency:
  - EX dependency: exactly one stall cycle; the next cycle resolves via fwd=1.
  - mfhi/mflo during BUSY: stalls through the md_done cycle and releases the following cycle.
- Simultaneous events:
  - ex_hazard together with md_start_id in IDLE: no md_go; the mult/div issues once the stall clears.
  - md_done and a new md_start_id in the same cycle: stall that cycle, issue on the next.
- Reset mid-operation (rst_n low while BUSY): return to IDLE immediately. The multiply/divide unit shares rst_n.
- md_timeout clears only on reset.

## Test plan
- EX producer $3, ID reads $3 as s: stall=1, bubble_ex=1 for one cycle. Next cycle fwd_s_sel=1, stall=0. stall_count=1.
- MEM and WB both write $5, ID reads $5 as t: fwd_t_sel=1 with no stall. With only the WB write present, fwd_t_sel=2. Same scenario with address $0: fwd=0, no stall.
- mult in ID with FSM IDLE: md_go pulses once, md_busy=1 the next cycle. mflo issued 2 cycles later with md_done 5 cycles after md_go: stall held until md_done, mflo proceeds the cycle after md_done.
- Branch (pc_we_id=1) depending on EX: pc_we=0 during the stall cycle, pc_we=1 the next cycle.
- md_done never returns: after 64 BUSY cycles md_timeout=1, md_busy=0, FSM IDLE.
- Counter preloaded near 0xFFFFFFFF by a forced stall run: increments wrap to 0x00000000. Async rst_n pulse mid-BUSY: all outputs return to their reset values without a clock edge.

Source files
------------

// File: rtl/hazard_control.sv
// -----------------------------------------------------------------------------
// hazard_control
//
// Interlock and scheduling controller for the five-stage core (IF, ID, EX,
// MEM, WB). It compares the operands read by the instruction in ID against
// the destinations of the EX, MEM and WB producers. From that it produces the
// stall/bubble pair and the operand forwarding selects. It also sequences the
// shared multi-cycle multiply/divide unit and counts stall cycles.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reg_s_addr_id, reg_t_addr_id     operand addresses of the ID instruction
//   uses_s_id, uses_t_id             ID instruction actually reads s / t
//   reg_d_we_*, reg_d_addr_*         write enable / destination in EX, MEM, WB
//   pc_we_id                         branch-taken request from decode
//   md_start_id, md_read_id          ID holds a mult/div, or an mfhi/mflo
//   md_done                          completion pulse from the mult/div unit
//   stall, bubble_ex                 hold PC + IF/ID, and null the ID/EX slot
//   pc_we                            branch enable gated by stall
//   fwd_s_sel, fwd_t_sel             0 = regfile, 1 = MEM result, 2 = WB result
//   md_go, md_busy, md_timeout       mult/div launch, occupancy, sticky error
//   stall_count                      free-running count of stalled cycles
//
// NUM_MD_CYCLES_MAX must be at least 2 and no more than 128, because the
// busy counter is 7 bits wide.
// -----------------------------------------------------------------------------
module hazard_control #(
    parameter int NUM_MD_CYCLES_MAX = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  reg_s_addr_id,
    input  logic [4:0]  reg_t_addr_id,
    input  logic        uses_s_id,
    input  logic        uses_t_id,
    input  logic        reg_d_we_ex,
    input  logic [4:0]  reg_d_addr_ex,
    input  logic        reg_d_we_mem,
    input  logic [4:0]  reg_d_addr_mem,
    input  logic        reg_d_we_wb,
    input  logic [4:0]  reg_d_addr_wb,
    input  logic        pc_we_id,
    input  logic        md_start_id,
    input  logic        md_read_id,
    input  logic        md_done,
    output logic        stall,
    output logic        bubble_ex,
    output logic        pc_we,
    output logic [1:0]  fwd_s_sel,
    output logic [1:0]  fwd_t_sel,
    output logic        md_go,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [31:0] stall_count
);

    localparam logic [6:0] MD_LAST_CYCLE = 7'(NUM_MD_CYCLES_MAX - 1);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    md_state_t   md_state_q, md_state_d;
    logic [6:0]  busy_cnt_q, busy_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cnt_q;

    logic s_ex, s_mem, s_wb;
    logic t_ex, t_mem, t_wb;
    logic ex_hazard, md_hazard;

    // A producer matches an operand only if the operand is really read, is
    // not $0, and the producer really writes that register.
    function automatic logic operand_match(input logic       uses,
                                           input logic [4:0] addr,
                                           input logic       we,
                                           input logic [4:0] dst);
        return uses && (addr != 5'd0) && we && (dst == addr);
    endfunction

    assign s_ex  = operand_match(uses_s_id, reg_s_addr_id, reg_d_we_ex,  reg_d_addr_ex);
    assign s_mem = operand_match(uses_s_id, reg_s_addr_id, reg_d_we_mem, reg_d_addr_mem);
    assign s_wb  = operand_match(uses_s_id, reg_s_addr_id, reg_d_we_wb,  reg_d_addr_wb);
    assign t_ex  = operand_match(uses_t_id, reg_t_addr_id, reg_d_we_ex,  reg_d_addr_ex);
    assign t_mem = operand_match(uses_t_id, reg_t_addr_id, reg_d_we_mem, reg_d_addr_mem);
    assign t_wb  = operand_match(uses_t_id, reg_t_addr_id, reg_d_we_wb,  reg_d_addr_wb);

    // The EX result is not available yet, so an EX match always costs a
    // stall; the dependency then resolves from MEM on the following cycle.
    assign ex_hazard = s_ex | t_ex;
    assign md_hazard = (md_start_id | md_read_id) & md_busy;
    assign stall     = ex_hazard | md_hazard;
    assign bubble_ex = stall;
    assign pc_we     = pc_we_id & ~stall;

    // The youngest completed producer (MEM) wins over WB. The selects are
    // kept valid during a stall as well.
    always_comb begin
        fwd_s_sel = 2'd0;
        fwd_t_sel = 2'd0;
        if (s_mem)      fwd_s_sel = 2'd1;
        else if (s_wb)  fwd_s_sel = 2'd2;
        if (t_mem)      fwd_t_sel = 2'd1;
        else if (t_wb)  fwd_t_sel = 2'd2;
    end

    // Multiply/divide sequencer, next-state logic. A launch waits for the
    // stall to clear. The busy counter bounds how long the unit may run
    // before the sequencer gives up and flags a timeout.
    always_comb begin
        md_state_d = md_state_q;
        busy_cnt_d = busy_cnt_q;
        timeout_d  = timeout_q;
        md_go      = 1'b0;
        case (md_state_q)
            MD_IDLE: begin
                busy_cnt_d = 7'd0;
                if (md_start_id && !stall) begin
                    md_go      = 1'b1;
                    md_state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (md_done) begin
                    md_state_d = MD_IDLE;
                    busy_cnt_d = 7'd0;
                end else if (busy_cnt_q == MD_LAST_CYCLE) begin
                    timeout_d  = 1'b1;
                    md_state_d = MD_IDLE;
                    busy_cnt_d = 7'd0;
                end else begin
                    busy_cnt_d = busy_cnt_q + 7'd1;
                end
            end
            default: begin
                md_state_d = MD_IDLE;
                busy_cnt_d = 7'd0;
            end
        endcase
    end

    // Sequencer state and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state_q <= MD_IDLE;
            busy_cnt_q <= 7'd0;
            timeout_q  <= 1'b0;
        end else begin
            md_state_q <= md_state_d;
            busy_cnt_q <= busy_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // The stall-cycle counter wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign md_busy     = (md_state_q == MD_BUSY);
    assign md_timeout  = timeout_q;
    assign stall_count = stall_cnt_q;

endmodule
